// File: rtl/exec_sequencer.sv
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle LEGv8 control sequencer (IDLE/DECODE/EXEC/MEM/WB)
//               with memory wait timeout and sticky error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        pc_src,
    output logic        done,
    output logic [1:0]  err
);

    localparam logic [1:0] c_ALUOP_DTYPE = 2'b00;
    localparam logic [1:0] c_ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] c_ALUOP_B     = 2'b11;
    localparam logic [3:0] c_TIMEOUT     = 4'(MEM_TIMEOUT);
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_MEMTO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_R   = 3'd0,
        K_LD  = 3'd1,
        K_ST  = 3'd2,
        K_CBZ = 3'd3,
        K_B   = 3'd4,
        K_ILL = 3'd5
    } kind_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_opcode;
    logic [1:0]  r_alu_op;
    logic        r_alu_src;
    logic [1:0]  r_err;
    logic [3:0]  r_cnt;
    kind_t       w_kind;
    logic [1:0]  w_dec_alu_op;
    logic        w_dec_alu_src;
    logic        w_timeout;

    assign instr_ready = rst_n && (r_state == S_IDLE);
    assign err         = r_err;
    assign w_timeout   = (r_cnt == c_TIMEOUT);

    // Classify the latched opcode and derive the ALU controls it implies.
    always_comb begin
        w_kind        = K_ILL;
        w_dec_alu_op  = r_alu_op;
        w_dec_alu_src = r_alu_src;
        casez (r_opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: begin
                w_kind        = K_R;
                w_dec_alu_op  = c_ALUOP_RTYPE;
                w_dec_alu_src = 1'b0;
            end
            11'b11111000010: begin
                w_kind        = K_LD;
                w_dec_alu_op  = c_ALUOP_DTYPE;
                w_dec_alu_src = 1'b1;
            end
            11'b11111000000: begin
                w_kind        = K_ST;
                w_dec_alu_op  = c_ALUOP_DTYPE;
                w_dec_alu_src = 1'b1;
            end
            11'b10110100???: begin
                w_kind        = K_CBZ;
                w_dec_alu_op  = c_ALUOP_CBZ;
                w_dec_alu_src = 1'b0;
            end
            11'b000101?????: begin
                w_kind        = K_B;
                w_dec_alu_op  = c_ALUOP_B;
                w_dec_alu_src = 1'b0;
            end
            default: w_kind = K_ILL;
        endcase
    end

    // Next-state and control strobes; ALU controls come live from DECODE,
    // then from the held copy for the rest of the instruction and in IDLE.
    always_comb begin
        w_next     = r_state;
        alu_op     = r_alu_op;
        alu_src    = r_alu_src;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_op  = w_dec_alu_op;
                alu_src = w_dec_alu_src;
                if (w_kind == K_ILL) begin
                    done     = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_kind)
                    K_R:        w_next = S_WB;
                    K_LD, K_ST: w_next = S_MEM;
                    K_CBZ: begin
                        done     = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        w_next   = S_IDLE;
                    end
                    K_B: begin
                        done     = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        w_next   = S_IDLE;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (w_timeout) begin
                    // Give up on the access: strobes drop, instruction retires.
                    done     = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    mem_read  = (w_kind == K_LD);
                    mem_write = (w_kind == K_ST);
                    if (mem_ready) begin
                        if (w_kind == K_LD) begin
                            w_next = S_WB;
                        end else begin
                            done     = 1'b1;
                            pc_write = 1'b1;
                            w_next   = S_IDLE;
                        end
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (w_kind == K_LD);
                pc_write   = 1'b1;
                done       = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, opcode latch, held ALU controls, error and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opcode  <= 11'd0;
            r_alu_op  <= 2'b00;
            r_alu_src <= 1'b0;
            r_err     <= 2'b00;
            r_cnt     <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && instr_valid) begin
                r_opcode <= opcode;
                r_err    <= 2'b00;
            end
            if (r_state == S_DECODE) begin
                if (w_kind == K_ILL) begin
                    r_err <= c_ERR_ILLEGAL;
                end else begin
                    r_alu_op  <= w_dec_alu_op;
                    r_alu_src <= w_dec_alu_src;
                end
            end
            // Counter stays clear outside MEM, so each MEM visit starts at 0.
            if (r_state == S_MEM) begin
                if (w_timeout) begin
                    r_err <= c_ERR_MEMTO;
                end else if (!mem_ready) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Directed self-checking bench for exec_sequencer with a
//               retirement scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_sequencer;

    localparam logic [1:0] DT = 2'b00;
    localparam logic [1:0] CB = 2'b01;
    localparam logic [1:0] RT = 2'b10;
    localparam logic [1:0] BR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [10:0] opcode = 11'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic        pc_write, pc_src, done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         lat;
        int         rd;
        int         wr;
        int         rw;
        logic       m2r;
        logic       ps;
        logic [1:0] er;
        logic [1:0] aop;
        logic       asrc;
    } exp_t;

    exp_t sb[$];

    exec_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input int rd, input int wr, input int rw,
                                input logic m2r, input logic ps, input logic [1:0] er,
                                input logic [1:0] aop, input logic asrc);
        exp_t e;
        e.lat = lat; e.rd = rd; e.wr = wr; e.rw = rw; e.m2r = m2r;
        e.ps = ps; e.er = er; e.aop = aop; e.asrc = asrc;
        return e;
    endfunction

    // One instruction: accept, step cycles until done, score the retirement.
    // mdelay < 0 keeps mem_ready low forever.
    task automatic run(input string nm, input logic [10:0] op, input logic z,
                       input int mdelay, input exp_t e, input bit legal);
        exp_t x;
        int nrd = 0, nwr = 0, nrw = 0, npw = 0;
        bit seen = 0;
        @(posedge clk); #1;
        instr_valid = 1'b1; opcode = op; zero = z; mem_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_accept_ready"}, instr_ready, 1);
        sb.push_back(e);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            instr_valid = 1'($urandom);
            opcode      = 11'($urandom);
            mem_ready   = (mdelay >= 0) && (k >= 3 + mdelay);
            @(negedge clk);
            chk({nm, "_busy_ready"}, instr_ready, 0);
            nrd += int'(mem_read); nwr += int'(mem_write);
            nrw += int'(reg_write); npw += int'(pc_write);
            if (k == 1 && legal) begin
                chk({nm, "_dec_alu_op"}, alu_op, e.aop);
                chk({nm, "_dec_alu_src"}, alu_src, e.asrc);
            end
            if (done) begin
                seen = 1;
                x = sb.pop_front();
                chk({nm, "_latency"}, k, x.lat);
                chk({nm, "_pc_src"}, pc_src, x.ps);
                chk({nm, "_mem_to_reg"}, mem_to_reg, x.m2r);
                chk({nm, "_alu_op"}, alu_op, x.aop);
                chk({nm, "_alu_src"}, alu_src, x.asrc);
            end
        end
        if (!seen) begin
            chk({nm, "_done_timeout"}, 0, 1);
            x = sb.pop_front();
        end
        chk({nm, "_mem_read_cycles"}, nrd, x.rd);
        chk({nm, "_mem_write_cycles"}, nwr, x.wr);
        chk({nm, "_reg_write_cycles"}, nrw, x.rw);
        chk({nm, "_pc_write_cycles"}, npw, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_err"}, err, x.er);
        chk({nm, "_idle_done"}, done, 0);
        chk({nm, "_idle_ready"}, instr_ready, 1);
        chk({nm, "_idle_alu_hold"}, alu_op, x.aop);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_ready", instr_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_strobes", {mem_read, mem_write, reg_write, pc_write, done}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run("add",   11'b10001011000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);
        run("sub",   11'b11001011000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);
        run("ldur",  11'b11111000010, 0, 2,  mk(6, 3, 0, 1, 1, 0, 2'b00, DT, 1), 1);
        run("orr",   11'b10101010000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);
        run("cbz1",  11'b10110100101, 1, 0,  mk(2, 0, 0, 0, 0, 1, 2'b00, CB, 0), 1);
        run("cbz0",  11'b10110100101, 0, 0,  mk(2, 0, 0, 0, 0, 0, 2'b00, CB, 0), 1);
        run("b",     11'b00010100011, 0, 0,  mk(2, 0, 0, 0, 0, 1, 2'b00, BR, 0), 1);
        run("stur0", 11'b11111000000, 0, 0,  mk(3, 0, 1, 0, 0, 0, 2'b00, DT, 1), 1);
        run("stur1", 11'b11111000000, 0, 1,  mk(4, 0, 2, 0, 0, 0, 2'b00, DT, 1), 1);
        run("sturto",11'b11111000000, 0, -1, mk(18, 0, 15, 0, 0, 0, 2'b10, DT, 1), 1);
        run("add2",  11'b10001011000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);
        run("and",   11'b10001010000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);
        run("ill0",  11'b00000000000, 0, 0,  mk(1, 0, 0, 0, 0, 0, 2'b01, RT, 0), 0);
        run("ill1",  11'b11111000001, 0, 0,  mk(1, 0, 0, 0, 0, 0, 2'b01, RT, 0), 0);

        // Reset while idle with a sticky error and held ALU controls
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("idle_rst_err", err, 0);
        chk("idle_rst_alu_op", alu_op, 0);
        chk("idle_rst_ready", instr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-cycle while LDUR waits in MEM
        @(posedge clk); #1;
        instr_valid = 1'b1; opcode = 11'b11111000010; mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        @(negedge clk);
        chk("abort_pre_mem_read", mem_read, 1);
        chk("abort_pre_alu_src", alu_src, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {mem_read, mem_write, reg_write, mem_to_reg,
                              pc_write, pc_src, done, alu_src, alu_op, err}, 0);
        chk("abort_ready", instr_ready, 0);
        @(posedge clk); #2;
        chk("abort_no_done", {done, mem_read}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_release_ready", instr_ready, 1);
        chk("abort_release_strobes", {mem_read, done}, 0);

        run("add3",  11'b10001011000, 0, 0,  mk(3, 0, 0, 1, 0, 0, 2'b00, RT, 0), 1);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
